uart_ctrl: RTL and testbench
============================

Name: uart_ctrl

Overview:
- Sequencer and buffer layer between the bus register file and one uart_core instance.
- Holds an outgoing-byte FIFO and an incoming-byte FIFO.
- Drives the core's start and config inputs so each transmitted byte is launched exactly once, and captures every received byte on the core's done pulse.
- Generates the core's synchronous active-high reset from the system reset and the enable bit.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..256
- LW, $clog2(DEPTH)+1, width of the level outputs

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset: asynchronous, active-low
- enable_i  in  1  controller enable; 0 holds the core in reset
- tx_wr_i  in  1  push tx_wdata_i into TX FIFO
- tx_wdata_i  in  8  byte to send
- tx_full_o  out  1  TX FIFO full
- tx_level_o  out  LW  TX FIFO occupancy
- tx_busy_o  out  1  TX sequencer active
- rx_rd_i  in  1  pop RX FIFO head
- rx_rdata_o  out  8  RX FIFO head (first-word fall-through)
- rx_empty_o  out  1  RX FIFO empty
- rx_level_o  out  LW  RX FIFO occupancy
- rx_ovf_o  out  1  sticky RX overflow
- ovf_clr_i  in  1  clear rx_ovf_o
- core_rst_o  out  1  to uart_core rst_i
- core_cfg_o  out  3  to uart_core cfg_i; [2:1] tied 0 so core done outputs are single-cycle pulses
- core_tx_data_o  out  8  to uart_core tx_data_i
- core_tx_done_i  in  1  from uart_core tx_done_o
- core_rx_done_i  in  1  from uart_core rx_done_o
- core_rx_data_i  in  8  from uart_core rx_data_o

Behaviour:
- Reset values (async, on rst_ni low):
  - FIFOs empty, levels 0, tx_full_o 0, rx_empty_o 1
  - rx_ovf_o 0, tx_busy_o 0, core_cfg_o 0, core_rst_o 1, rx_rdata_o 0
- core_rst_o:
  - 2-flop stage, async-set by reset, shifting in !enable_i.
  - Deasserts on the 2nd rising edge after rst_ni rises with enable_i=1.
  - Asserts 2 cycles after enable_i falls.
- TX FSM, states TX_IDLE and TX_ACTIVE:
  - TX_IDLE -> TX_ACTIVE when TX level != 0, enable_i=1 and core_rst_o=0.
  - In TX_ACTIVE:
    - core_cfg_o[0]=1 and core_tx_data_o=TX head, stable until pop.
    - core_tx_done_i pulse pops the head the same edge.
    - If the level after the pop is 0: -> TX_IDLE and core_cfg_o[0]=0 from the next cycle.
    - Otherwise stay; the next head is presented from the next cycle.
  - core_cfg_o[0] is registered (0 in TX_IDLE); tx_busy_o = (state==TX_ACTIVE).
  - enable_i=0 forces TX_IDLE without a pop; the interrupted byte is resent in full after re-enable.
- TX push:
  - Accepted when !tx_full_o, with fullness evaluated on the current level.
  - Push while full is ignored, even when a pop occurs that cycle.
  - Push and pop together keep the level unchanged.
- RX capture:
  - A core_rx_done_i pulse writes core_rx_data_i into the RX FIFO.
  - The byte is visible on rx_rdata_o with rx_empty_o=0 the next cycle.
  - Done pulses are ignored while core_rst_o=1.
- RX full plus done pulse:
  - The byte is dropped and rx_ovf_o is set.
  - A simultaneous rx_rd_i does not make room that cycle.
- RX pop:
  - rx_rd_i when empty is ignored; rx_rdata_o holds its last value.
  - Pop and push together keep the level unchanged.
- rx_ovf_o: cleared by ovf_clr_i; a set in the same cycle wins.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; levels 0..DEPTH.
- enable_i=0 does not flush the FIFOs; the bus may still push and pop.

Optional Feature:
- UART_CTRL_IRQ_EN defined:
  - Adds input irq_mask_i[2:0] and output irq_o.
  - irq_o = registered OR of (!rx_empty_o & mask[0]) | (tx_level_o==0 & mask[1]) | (rx_ovf_o & mask[2]).
  - Reset value 0; one cycle latency from the cause.
- Undefined: both ports are absent and no interrupt logic is built.

Test Plan:
- Reset with enable_i=1: all outputs at reset values; core_rst_o falls exactly 2 edges after rst_ni rises.
- Push 0xA5, 0x3C, then a model pulses core_tx_done_i twice:
  - core_tx_data_o shows 0xA5, then 0x3C.
  - core_cfg_o[0] drops the cycle after the 2nd pulse.
  - tx_level_o returns 0; tx_busy_o goes low.
- Push DEPTH+1 bytes with no done pulses: tx_full_o=1, level=DEPTH, the extra byte is discarded.
- DEPTH+1 rx done pulses with data 0..DEPTH:
  - rx_ovf_o set, level DEPTH, rx_rdata_o=0x00.
  - Pops return 0..DEPTH-1.
  - ovf_clr_i clears rx_ovf_o.
- Drop enable_i mid-byte with 3 bytes queued:
  - core_rst_o asserts, tx_level_o stays 3.
  - After re-enable, the same head byte is presented again.
- With UART_CTRL_IRQ_EN and mask=3'b001: one rx done pulse gives irq_o=1 two cycles later; popping the byte clears it.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: TX/RX byte FIFOs plus start/done sequencing and reset generation for one uart_core.
// Optional interrupt output (irq_mask_i / irq_o) is built only when UART_CTRL_IRQ_EN is defined.
module uart_ctrl #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          tx_wr_i,
    input  logic [7:0]    tx_wdata_i,
    output logic          tx_full_o,
    output logic [LW-1:0] tx_level_o,
    output logic          tx_busy_o,
    input  logic          rx_rd_i,
    output logic [7:0]    rx_rdata_o,
    output logic          rx_empty_o,
    output logic [LW-1:0] rx_level_o,
    output logic          rx_ovf_o,
    input  logic          ovf_clr_i,
    output logic          core_rst_o,
    output logic [2:0]    core_cfg_o,
    output logic [7:0]    core_tx_data_o,
    input  logic          core_tx_done_i,
    input  logic          core_rx_done_i,
    input  logic [7:0]    core_rx_data_i
`ifdef UART_CTRL_IRQ_EN
    ,
    input  logic [2:0]    irq_mask_i,
    output logic          irq_o
`endif
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {TX_IDLE, TX_ACTIVE} tx_state_e;

    tx_state_e     tx_state, tx_state_next;
    logic [1:0]    rst_sync;
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [LW-1:0] tx_level;
    logic          tx_push, tx_pop, tx_start_q, tx_start_d;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [LW-1:0] rx_level;
    logic          rx_push, rx_pop, rx_ovf_set, rx_ovf_q;
    logic [7:0]    rx_hold_q;

    // Core reset follows !enable_i through two flops so it releases cleanly after system reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], ~enable_i};
        end
    end

    assign core_rst_o = rst_sync[1];

    assign tx_full_o  = (tx_level == FULL_LVL);
    assign tx_level_o = tx_level;
    assign tx_push    = tx_wr_i && !tx_full_o;
    assign tx_pop     = (tx_state == TX_ACTIVE) && enable_i && core_tx_done_i;

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state   <= TX_IDLE;
            tx_start_q <= 1'b0;
        end else begin
            tx_state   <= tx_state_next;
            tx_start_q <= tx_start_d;
        end
    end

    // Dropping enable abandons the byte without popping it, so it is resent after re-enable.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (tx_level != '0 && enable_i && !core_rst_o) tx_state_next = TX_ACTIVE;
            end
            TX_ACTIVE: begin
                if (!enable_i) begin
                    tx_state_next = TX_IDLE;
                end else if (tx_pop && tx_level == LW'(1) && !tx_push) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy_o  = (tx_state == TX_ACTIVE);
        tx_start_d = (tx_state_next == TX_ACTIVE);
    end

    assign core_cfg_o     = {2'b00, tx_start_q};
    assign core_tx_data_o = tx_mem[tx_rd_ptr];

    assign rx_empty_o = (rx_level == '0);
    assign rx_level_o = rx_level;
    assign rx_push    = core_rx_done_i && !core_rst_o && (rx_level != FULL_LVL);
    assign rx_ovf_set = core_rx_done_i && !core_rst_o && (rx_level == FULL_LVL);
    assign rx_pop     = rx_rd_i && !rx_empty_o;

    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= core_rx_data_i;
        end
    end

    // rx_hold_q remembers the last presented head so the read port holds its value once empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            rx_ovf_q  <= 1'b0;
            rx_hold_q <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            rx_level <= rx_level + LW'(rx_push) - LW'(rx_pop);
            if (rx_ovf_set) begin
                rx_ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                rx_ovf_q <= 1'b0;
            end
            if (!rx_empty_o) rx_hold_q <= rx_mem[rx_rd_ptr];
        end
    end

    assign rx_ovf_o   = rx_ovf_q;
    assign rx_rdata_o = rx_empty_o ? rx_hold_q : rx_mem[rx_rd_ptr];

`ifdef UART_CTRL_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (!rx_empty_o && irq_mask_i[0]) ||
                     ((tx_level == '0) && irq_mask_i[1]) ||
                     (rx_ovf_q && irq_mask_i[2]);
        end
    end
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: RX vector table plus scoreboard-driven TX drain, RX overflow and enable-drop sequences.
// Interrupt checks are included when UART_CTRL_IRQ_EN is defined.
module tb_uart_ctrl;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          tx_wr;
    logic [7:0]    tx_wdata;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          tx_busy;
    logic          rx_rd;
    logic [7:0]    rx_rdata;
    logic          rx_empty;
    logic [LW-1:0] rx_level;
    logic          rx_ovf;
    logic          ovf_clr;
    logic          core_rst;
    logic [2:0]    core_cfg;
    logic [7:0]    core_tx_data;
    logic          core_tx_done;
    logic          core_rx_done;
    logic [7:0]    core_rx_data;
`ifdef UART_CTRL_IRQ_EN
    logic [2:0]    irq_mask;
    logic          irq;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    typedef struct {
        logic          done;
        logic [7:0]    data;
        logic          rd;
        logic [LW-1:0] exp_level;
        logic          exp_empty;
        logic [7:0]    exp_rdata;
    } rx_vec_t;

    rx_vec_t rx_tab [8];

    uart_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .tx_wr_i        (tx_wr),
        .tx_wdata_i     (tx_wdata),
        .tx_full_o      (tx_full),
        .tx_level_o     (tx_level),
        .tx_busy_o      (tx_busy),
        .rx_rd_i        (rx_rd),
        .rx_rdata_o     (rx_rdata),
        .rx_empty_o     (rx_empty),
        .rx_level_o     (rx_level),
        .rx_ovf_o       (rx_ovf),
        .ovf_clr_i      (ovf_clr),
        .core_rst_o     (core_rst),
        .core_cfg_o     (core_cfg),
        .core_tx_data_o (core_tx_data),
        .core_tx_done_i (core_tx_done),
        .core_rx_done_i (core_rx_done),
        .core_rx_data_i (core_rx_data)
`ifdef UART_CTRL_IRQ_EN
        ,
        .irq_mask_i     (irq_mask),
        .irq_o          (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input rx_vec_t v);
        core_rx_done = v.done;
        core_rx_data = v.data;
        rx_rd        = v.rd;
        tick();
        core_rx_done = 1'b0;
        rx_rd        = 1'b0;
    endtask

    task automatic pushTx(input logic [7:0] b);
        tx_wr    = 1'b1;
        tx_wdata = b;
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic waitBusy(input int budget);
        int cycles = 0;
        while (!tx_busy && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput("tx_busy_wait", {31'd0, tx_busy}, 32'd1);
    endtask

    // Core model: answers each presented byte with a done pulse and scores it against the queue.
    task automatic drainTx(input int budget);
        int cycles = 0;
        while (tx_q.size() > 0 && cycles < budget) begin
            if (tx_busy) begin
                checkOutput("tx_data", {24'd0, core_tx_data}, {24'd0, tx_q[0]});
                checkOutput("tx_start", {31'd0, core_cfg[0]}, 32'd1);
                core_tx_done = 1'b1;
                tick();
                core_tx_done = 1'b0;
                void'(tx_q.pop_front());
            end else begin
                tick();
            end
            cycles++;
        end
        if (tx_q.size() != 0) begin
            checkOutput("tx_drain_timeout", tx_q.size(), 32'd0);
            tx_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        tx_wr        = 1'b0;
        tx_wdata     = 8'h00;
        rx_rd        = 1'b0;
        ovf_clr      = 1'b0;
        core_tx_done = 1'b0;
        core_rx_done = 1'b0;
        core_rx_data = 8'h00;
`ifdef UART_CTRL_IRQ_EN
        irq_mask     = 3'b000;
`endif

        rx_tab[0] = '{1'b1, 8'h11, 1'b0, LW'(1), 1'b0, 8'h11};
        rx_tab[1] = '{1'b1, 8'h22, 1'b0, LW'(2), 1'b0, 8'h11};
        rx_tab[2] = '{1'b1, 8'h33, 1'b1, LW'(2), 1'b0, 8'h22};
        rx_tab[3] = '{1'b0, 8'h00, 1'b1, LW'(1), 1'b0, 8'h33};
        rx_tab[4] = '{1'b1, 8'h44, 1'b1, LW'(1), 1'b0, 8'h44};
        rx_tab[5] = '{1'b0, 8'h00, 1'b1, LW'(0), 1'b1, 8'h44};
        rx_tab[6] = '{1'b0, 8'h00, 1'b1, LW'(0), 1'b1, 8'h44};
        rx_tab[7] = '{1'b0, 8'h00, 1'b0, LW'(0), 1'b1, 8'h44};

        tick();
        tick();
        checkOutput("rst_tx_full", {31'd0, tx_full}, 32'd0);
        checkOutput("rst_tx_level", {28'd0, tx_level}, 32'd0);
        checkOutput("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        checkOutput("rst_rx_level", {28'd0, rx_level}, 32'd0);
        checkOutput("rst_rx_ovf", {31'd0, rx_ovf}, 32'd0);
        checkOutput("rst_core_cfg", {29'd0, core_cfg}, 32'd0);
        checkOutput("rst_core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("rst_rx_rdata", {24'd0, rx_rdata}, 32'd0);
`ifdef UART_CTRL_IRQ_EN
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
`endif

        rst_n = 1'b1;
        tick();
        checkOutput("core_rst_edge1", {31'd0, core_rst}, 32'd1);
        tick();
        checkOutput("core_rst_edge2", {31'd0, core_rst}, 32'd0);

        $display("[TB] two-byte transmit");
        pushTx(8'hA5);
        pushTx(8'h3C);
        checkOutput("tx_level_two", {28'd0, tx_level}, 32'd2);
        checkOutput("tx_busy_two", {31'd0, tx_busy}, 32'd1);
        drainTx(20);
        checkOutput("tx_start_drop", {31'd0, core_cfg[0]}, 32'd0);
        checkOutput("tx_busy_done", {31'd0, tx_busy}, 32'd0);
        checkOutput("tx_level_done", {28'd0, tx_level}, 32'd0);

        $display("[TB] transmit FIFO fill");
        for (int i = 0; i <= DEPTH; i++) pushTx(8'h10 + 8'(i));
        checkOutput("tx_full_set", {31'd0, tx_full}, 32'd1);
        checkOutput("tx_level_full", {28'd0, tx_level}, DEPTH);
        checkOutput("tx_full_head", {24'd0, core_tx_data}, {24'd0, tx_q[0]});
        tx_wr        = 1'b1;
        tx_wdata     = 8'hEE;
        core_tx_done = 1'b1;
        tick();
        tx_wr        = 1'b0;
        core_tx_done = 1'b0;
        void'(tx_q.pop_front());
        checkOutput("tx_push_full_pop", {28'd0, tx_level}, DEPTH - 1);
        checkOutput("tx_full_clear", {31'd0, tx_full}, 32'd0);
        drainTx(40);
        checkOutput("tx_level_drained", {28'd0, tx_level}, 32'd0);

        $display("[TB] receive overflow");
        for (int i = 0; i <= DEPTH; i++) begin
            core_rx_done = 1'b1;
            core_rx_data = i[7:0];
            if (rx_q.size() < DEPTH) rx_q.push_back(i[7:0]);
            tick();
        end
        core_rx_done = 1'b0;
        checkOutput("rx_ovf_set", {31'd0, rx_ovf}, 32'd1);
        checkOutput("rx_level_full", {28'd0, rx_level}, DEPTH);
        checkOutput("rx_head_full", {24'd0, rx_rdata}, 32'd0);
        core_rx_done = 1'b1;
        core_rx_data = 8'h55;
        ovf_clr      = 1'b1;
        tick();
        core_rx_done = 1'b0;
        checkOutput("rx_ovf_set_wins", {31'd0, rx_ovf}, 32'd1);
        checkOutput("rx_level_drop", {28'd0, rx_level}, DEPTH);
        tick();
        ovf_clr = 1'b0;
        checkOutput("rx_ovf_clear", {31'd0, rx_ovf}, 32'd0);
        core_rx_done = 1'b1;
        core_rx_data = 8'h77;
        rx_rd        = 1'b1;
        tick();
        core_rx_done = 1'b0;
        rx_rd        = 1'b0;
        void'(rx_q.pop_front());
        checkOutput("rx_full_rd_no_room", {28'd0, rx_level}, DEPTH - 1);
        checkOutput("rx_ovf_reset", {31'd0, rx_ovf}, 32'd1);
        while (rx_q.size() > 0) begin
            checkOutput("rx_data", {24'd0, rx_rdata}, {24'd0, rx_q[0]});
            rx_rd = 1'b1;
            tick();
            rx_rd = 1'b0;
            void'(rx_q.pop_front());
        end
        checkOutput("rx_empty_drained", {31'd0, rx_empty}, 32'd1);
        checkOutput("rx_hold_last", {24'd0, rx_rdata}, DEPTH - 1);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        checkOutput("rx_rd_empty_hold", {24'd0, rx_rdata}, DEPTH - 1);
        checkOutput("rx_rd_empty_level", {28'd0, rx_level}, 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("rx_ovf_clear2", {31'd0, rx_ovf}, 32'd0);

        $display("[TB] receive vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(rx_tab[i]);
            checkOutput($sformatf("rx_vec%0d_level", i), {28'd0, rx_level}, {28'd0, rx_tab[i].exp_level});
            checkOutput($sformatf("rx_vec%0d_empty", i), {31'd0, rx_empty}, {31'd0, rx_tab[i].exp_empty});
            checkOutput($sformatf("rx_vec%0d_rdata", i), {24'd0, rx_rdata}, {24'd0, rx_tab[i].exp_rdata});
        end

        $display("[TB] enable drop mid-byte");
        pushTx(8'hB1);
        pushTx(8'hB2);
        pushTx(8'hB3);
        waitBusy(10);
        checkOutput("en_head_before", {24'd0, core_tx_data}, 32'hB1);
        enable = 1'b0;
        tick();
        checkOutput("en_busy_forced", {31'd0, tx_busy}, 32'd0);
        checkOutput("en_core_rst_1", {31'd0, core_rst}, 32'd0);
        tick();
        checkOutput("en_core_rst_2", {31'd0, core_rst}, 32'd1);
        checkOutput("en_tx_level", {28'd0, tx_level}, 32'd3);
        core_rx_done = 1'b1;
        core_rx_data = 8'h99;
        tick();
        core_rx_done = 1'b0;
        checkOutput("en_rx_ignored", {28'd0, rx_level}, 32'd0);
        enable = 1'b1;
        waitBusy(10);
        checkOutput("en_head_resent", {24'd0, core_tx_data}, 32'hB1);
        drainTx(20);
        checkOutput("en_tx_level_done", {28'd0, tx_level}, 32'd0);

`ifdef UART_CTRL_IRQ_EN
        $display("[TB] interrupt");
        irq_mask = 3'b001;
        tick();
        checkOutput("irq_idle", {31'd0, irq}, 32'd0);
        core_rx_done = 1'b1;
        core_rx_data = 8'h5A;
        tick();
        core_rx_done = 1'b0;
        checkOutput("irq_lat1", {31'd0, irq}, 32'd0);
        tick();
        checkOutput("irq_lat2", {31'd0, irq}, 32'd1);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        checkOutput("irq_pop_edge", {31'd0, irq}, 32'd1);
        tick();
        checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
